uart_fifo_sched: RTL
====================

Name: uart_fifo_sched

Overview:
- Controller for the shared UART TX byte FIFO.
- Front end: round-robin arbiter that lets NREQ requesters share the FIFO write port, with a grant locked for a burst.
- Back end: drain sequencer that pops the FIFO (one-cycle registered read data) and hands each byte to the UART transmitter via a start/busy handshake.
- Sits between the requester blocks, the FIFO and the UART TX serializer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width; matches the FIFO width.
- MAX_BURST, 16, maximum beats per grant before forced rotation (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- enable  in  1  drain enable; arbitration runs regardless.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*WIDTH  packed data, requester i at [i*WIDTH +: WIDTH].
- req_last  in  NREQ  last beat of the requester's packet.
- req_ready  out  NREQ  beat accepted when valid&&ready.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_din  out  WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_dout  in  WIDTH  FIFO read data; valid the cycle after an accepted read.
- fifo_empty  in  1  FIFO empty flag.
- tx_start  out  1  one-cycle start pulse to the UART TX.
- tx_data  out  WIDTH  byte for the UART TX; held stable until the next start.
- tx_busy  in  1  UART TX busy; asserted no later than the cycle after tx_start.
- grant_id  out  $clog2(NREQ)  current or last granted requester.
- grant_active  out  1  a grant is held.
- sent_count  out  16  bytes handed to the UART TX; wraps at 2^16.

Behaviour:

Reset (rst_n low, asynchronous):
- Both FSMs return to IDLE; the requester at index NREQ-1 is treated as the last granted.
- All outputs are 0: req_ready, fifo_wr_en, fifo_rd_en, tx_start, tx_data, grant_id, grant_active, sent_count, beat counter.
- Reset mid-burst or mid-byte abandons the operation; no partial handshake resumes.

Arbiter FSM, states A_IDLE and A_GRANT:
- A_IDLE: if any req_valid is high, pick the first valid index after last_grant (cyclic). On the next edge, grant_id takes that index, grant_active=1, beat counter=0, state moves to A_GRANT. Grant latency is one cycle.
- A_GRANT: req_ready[grant_id] = !fifo_full, combinational; all other req_ready bits are 0.
- fifo_wr_en = req_valid[g] && req_ready[g]; fifo_din = req_data[g].
- On an accepted beat with req_last=1, or on beat counter==MAX_BURST-1, the FSM goes to A_IDLE, grant_active=0 and last_grant is set to g. Otherwise the beat counter increments.
- A requester dropping valid mid-burst keeps the grant; there is no timeout.
- A single requester that stays valid is re-granted after a one-cycle A_IDLE gap.

Drain FSM, states D_IDLE, D_FETCH, D_START, D_BUSY:
- D_IDLE: fifo_rd_en = enable && !fifo_empty && !tx_busy && !fifo_wr_en, combinational. If it is asserted, go to D_FETCH.
- D_FETCH: register tx_data<=fifo_dout and tx_start<=1, then go to D_START.
- D_START: tx_start is high for exactly this cycle; it is cleared on exit. sent_count increments. Go to D_BUSY.
- D_BUSY: go to D_IDLE when tx_busy==0. Minimum spacing between reads is 4 cycles.

Write/read collision rule:
- fifo_wr_en and fifo_rd_en are never high in the same cycle; the write wins.
- On a collision the read retries the next cycle with all conditions re-evaluated.
- This rule is mandatory: the shared FIFO does not update its occupancy correctly on a simultaneous read and write.

Enable and boundaries:
- enable deasserted stops new reads only; a byte already in D_FETCH/D_START/D_BUSY completes.
- FIFO full: req_ready drops the same cycle and the beat is held by the requester.
- FIFO empty: no read is issued.
- sent_count wraps 0xFFFF to 0x0000.

Test Plan:
- Reset while mid-burst and with tx_start pending → all outputs 0 immediately. After release, req_valid=4'b0001 gives grant_id=0 one cycle later.
- req_valid=4'b1111, every beat req_last=1, fifo not full → grant order 0,1,2,3,0. Each grant is 1 beat with a 1-cycle A_IDLE gap between grants.
- Requester 2 sends 20 beats with no last, MAX_BURST=16 → 16 beats accepted, then rotation to the next valid requester. Requester 2 resumes on its next turn.
- fifo_full pulsed for 3 cycles mid-burst → req_ready low for exactly those 3 cycles. No beat is lost or duplicated; fifo_din matches the source sequence.
- FIFO preloaded with 0x41,0x42,0x43; tx_busy modelled high for 10 cycles after each start → tx_start pulses carry 0x41,0x42,0x43 in order. Pulses are ≥12 cycles apart; sent_count=3.
- Continuous writes with the FIFO non-empty → fifo_wr_en&&fifo_rd_en is never 1. The read issues in the first write-free cycle.

Source files
------------

// File: rtl/uart_fifo_sched.sv
// Shared UART TX FIFO controller: round-robin burst arbiter on the write port
// and a pop/start/busy drain sequencer on the read port.
module uart_fifo_sched #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   output logic                    fifo_wr_en,
   output logic [WIDTH-1:0]        fifo_din,
   input  logic                    fifo_full,
   output logic                    fifo_rd_en,
   input  logic [WIDTH-1:0]        fifo_dout,
   input  logic                    fifo_empty,
   output logic                    tx_start,
   output logic [WIDTH-1:0]        tx_data,
   input  logic                    tx_busy,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    grant_active,
   output logic [15:0]             sent_count,
   output logic [2:0]              dbg_state
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic {A_IDLE, A_GRANT} arb_state_e;
   typedef enum logic [1:0] {D_IDLE, D_FETCH, D_START, D_BUSY} drain_state_e;

   // Handshakes: a requester beat transfers on a cycle where req_valid[i] and
   // req_ready[i] are both high; the UART takes a byte on the tx_start pulse and
   // reports completion by dropping tx_busy.

   arb_state_e       arb_state_q, arb_state_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic             grant_active_q, grant_active_d;
   logic [IDW-1:0]   last_grant_q, last_grant_d;
   logic [CW-1:0]    beat_cnt_q, beat_cnt_d;

   drain_state_e     drain_state_q, drain_state_d;
   logic [WIDTH-1:0] tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic [15:0]      sent_count_q, sent_count_d;

   logic             pick_found;
   logic [IDW-1:0]   pick_idx;

   // First valid requester strictly after the last granted one, cyclically.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!pick_found && req_valid[(int'(last_grant_q) + k) % NREQ]) begin
            pick_found = 1'b1;
            pick_idx   = IDW'((int'(last_grant_q) + k) % NREQ);
         end
      end
   end

   always_comb begin
      arb_state_d    = arb_state_q;
      grant_id_d     = grant_id_q;
      grant_active_d = grant_active_q;
      last_grant_d   = last_grant_q;
      beat_cnt_d     = beat_cnt_q;
      req_ready      = '0;
      fifo_wr_en     = 1'b0;
      fifo_din       = '0;
      case (arb_state_q)
         A_IDLE: begin
            if (pick_found) begin
               arb_state_d    = A_GRANT;
               grant_id_d     = pick_idx;
               grant_active_d = 1'b1;
               beat_cnt_d     = '0;
            end
         end
         A_GRANT: begin
            req_ready[grant_id_q] = !fifo_full;
            fifo_wr_en            = req_valid[grant_id_q] && !fifo_full;
            fifo_din              = req_data[grant_id_q*WIDTH +: WIDTH];
            if (fifo_wr_en) begin
               if (req_last[grant_id_q] || (beat_cnt_q == CW'(MAX_BURST - 1))) begin
                  arb_state_d    = A_IDLE;
                  grant_active_d = 1'b0;
                  last_grant_d   = grant_id_q;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         default: arb_state_d = A_IDLE;
      endcase
   end

   // rst_n gates the read strobe so the FIFO is never popped while held in reset.
   always_comb begin
      drain_state_d = drain_state_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = tx_start_q;
      sent_count_d  = sent_count_q;
      fifo_rd_en    = 1'b0;
      case (drain_state_q)
         D_IDLE: begin
            fifo_rd_en = rst_n && enable && !fifo_empty && !tx_busy && !fifo_wr_en;
            if (fifo_rd_en) drain_state_d = D_FETCH;
         end
         D_FETCH: begin
            tx_data_d     = fifo_dout;
            tx_start_d    = 1'b1;
            drain_state_d = D_START;
         end
         D_START: begin
            tx_start_d    = 1'b0;
            sent_count_d  = sent_count_q + 16'd1;
            drain_state_d = D_BUSY;
         end
         D_BUSY: begin
            if (!tx_busy) drain_state_d = D_IDLE;
         end
         default: drain_state_d = D_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arb_state_q    <= A_IDLE;
         grant_id_q     <= '0;
         grant_active_q <= 1'b0;
         last_grant_q   <= IDW'(NREQ - 1);
         beat_cnt_q     <= '0;
         drain_state_q  <= D_IDLE;
         tx_data_q      <= '0;
         tx_start_q     <= 1'b0;
         sent_count_q   <= '0;
      end else begin
         arb_state_q    <= arb_state_d;
         grant_id_q     <= grant_id_d;
         grant_active_q <= grant_active_d;
         last_grant_q   <= last_grant_d;
         beat_cnt_q     <= beat_cnt_d;
         drain_state_q  <= drain_state_d;
         tx_data_q      <= tx_data_d;
         tx_start_q     <= tx_start_d;
         sent_count_q   <= sent_count_d;
      end
   end

   assign grant_id     = grant_id_q;
   assign grant_active = grant_active_q;
   assign tx_start     = tx_start_q;
   assign tx_data      = tx_data_q;
   assign sent_count   = sent_count_q;
   assign dbg_state    = {arb_state_q, drain_state_q};

endmodule
